alu_exec: RTL and testbench

- 32-bit integer ALU for the Execute (E) stage of the 5-stage MIPS pipeline.
- Computes arithmetic, logic, compare and shift results combinationally from the forwarded operands.
- Also drives a registered copy of the result into the E/M pipeline register, with stall and flush control.
- Single clock domain; asynchronous active-low reset.

---
 rtl/alu_pkg.sv | 28 ++
 rtl/alu_exec_if.sv | 25 ++
 rtl/alu_shifter.sv | 19 +
 rtl/alu_exec.sv | 83 ++++++++
 tb/tb_alu_exec.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared ALU operation encoding and shifter mode type for the E stage
// and the controller decoder.
package alu_pkg;

    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_AND   = 4'd2;
    localparam logic [3:0] ALU_OR    = 4'd3;
    localparam logic [3:0] ALU_XOR   = 4'd4;
    localparam logic [3:0] ALU_NOR   = 4'd5;
    localparam logic [3:0] ALU_SLT   = 4'd6;
    localparam logic [3:0] ALU_SLTU  = 4'd7;
    localparam logic [3:0] ALU_LUI   = 4'd8;
    localparam logic [3:0] ALU_SLL   = 4'd9;
    localparam logic [3:0] ALU_SRL   = 4'd10;
    localparam logic [3:0] ALU_SRA   = 4'd11;
    localparam logic [3:0] ALU_SLLV  = 4'd12;
    localparam logic [3:0] ALU_SRLV  = 4'd13;
    localparam logic [3:0] ALU_SRAV  = 4'd14;
    localparam logic [3:0] ALU_PASSB = 4'd15;

    typedef enum logic [1:0] {
        SH_LEFT,
        SH_RIGHT_LOG,
        SH_RIGHT_ARITH
    } shift_mode_t;

endpackage

// File: rtl/alu_exec_if.sv
// Operand/control/result bundle between the E-stage datapath and the ALU.
interface alu_exec_if #(
    parameter int WIDTH = 32
);
    logic             en;
    logic             clr;
    logic [WIDTH-1:0] SrcA_E;
    logic [WIDTH-1:0] SrcB_E;
    logic [4:0]       Shift_E;
    logic [3:0]       ALUCtrl;
    logic [WIDTH-1:0] AO_E;
    logic             Ovf_E;
    logic [WIDTH-1:0] AO_M;
    logic             Ovf_M;

    modport master (
        output en, clr, SrcA_E, SrcB_E, Shift_E, ALUCtrl,
        input  AO_E, Ovf_E, AO_M, Ovf_M
    );

    modport slave (
        input  en, clr, SrcA_E, SrcB_E, Shift_E, ALUCtrl,
        output AO_E, Ovf_E, AO_M, Ovf_M
    );
endinterface

// File: rtl/alu_shifter.sv
// 32-bit barrel shifter: left, logical right or arithmetic right.
import alu_pkg::*;

module alu_shifter (
    input  logic [31:0]  data,
    input  logic [4:0]   amt,
    input  shift_mode_t  mode,
    output logic [31:0]  result
);
    always_comb begin
        result = data;
        case (mode)
            SH_LEFT:        result = data << amt;
            SH_RIGHT_LOG:   result = data >> amt;
            SH_RIGHT_ARITH: result = $unsigned($signed(data) >>> amt);
            default:        result = data;
        endcase
    end
endmodule

// File: rtl/alu_exec.sv
// Execute-stage ALU: combinational result/overflow plus the E/M result register
// with stall (en) and flush (clr) control.
import alu_pkg::*;

module alu_exec #(
    parameter int WIDTH = 32
) (
    input logic       clk,
    input logic       rst_n,
    alu_exec_if.slave bus
);
    logic [WIDTH-1:0] a, b;
    logic [WIDTH-1:0] sum, diff, shift_res, result;
    logic [4:0]       shift_amt;
    shift_mode_t      shift_mode;
    logic             ovf;
    logic             is_var_shift;

    assign a    = bus.SrcA_E;
    assign b    = bus.SrcB_E;
    assign sum  = a + b;
    assign diff = a - b;

    assign is_var_shift = (bus.ALUCtrl >= ALU_SLLV) && (bus.ALUCtrl <= ALU_SRAV);
    assign shift_amt    = is_var_shift ? a[4:0] : bus.Shift_E;

    always_comb begin
        shift_mode = SH_RIGHT_ARITH;
        case (bus.ALUCtrl)
            ALU_SLL, ALU_SLLV: shift_mode = SH_LEFT;
            ALU_SRL, ALU_SRLV: shift_mode = SH_RIGHT_LOG;
            default:           shift_mode = SH_RIGHT_ARITH;
        endcase
    end

    alu_shifter u_shifter (
        .data   (b),
        .amt    (shift_amt),
        .mode   (shift_mode),
        .result (shift_res)
    );

    always_comb begin
        result = '0;
        ovf    = 1'b0;
        case (bus.ALUCtrl)
            ALU_ADD: begin
                result = sum;
                ovf    = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            ALU_SUB: begin
                result = diff;
                ovf    = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            ALU_AND:   result = a & b;
            ALU_OR:    result = a | b;
            ALU_XOR:   result = a ^ b;
            ALU_NOR:   result = ~(a | b);
            ALU_SLT:   result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_SLTU:  result = {{(WIDTH-1){1'b0}}, (a < b)};
            ALU_LUI:   result = {b[15:0], 16'h0000};
            ALU_PASSB: result = b;
            default:   result = shift_res;
        endcase
    end

    assign bus.AO_E  = result;
    assign bus.Ovf_E = ovf;

    // Flush outranks load so a squashed instruction never reaches M.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.AO_M  <= '0;
            bus.Ovf_M <= 1'b0;
        end else if (bus.clr) begin
            bus.AO_M  <= '0;
            bus.Ovf_M <= 1'b0;
        end else if (bus.en) begin
            bus.AO_M  <= result;
            bus.Ovf_M <= ovf;
        end
    end
endmodule

// File: tb/tb_alu_exec.sv
// Self-checking bench for alu_exec: directed vector table, pipeline/reset
// sequences and a randomised sweep against an independent reference model.
import alu_pkg::*;

module tb_alu_exec;
    logic clk;
    logic rst_n;

    alu_exec_if #(.WIDTH(32)) bus ();

    alu_exec #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [3:0]  ctrl;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  sh;
        logic [31:0] exp_ao;
        logic        exp_ovf;
    } vec_t;

    typedef struct {
        logic [31:0] ao;
        logic        ovf;
    } sb_t;

    int unsigned errors = 0;
    int unsigned checks = 0;
    sb_t         sb_q[$];
    vec_t        vecs[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    function automatic sb_t model(input logic [3:0] c, input logic [31:0] a,
                                  input logic [31:0] b, input logic [4:0] sh);
        sb_t         r;
        logic [32:0] wide;
        logic [4:0]  n;
        n = (c >= 4'd12 && c <= 4'd14) ? a[4:0] : sh;
        r.ovf = 1'b0;
        r.ao  = '0;
        case (c)
            4'd0:  begin wide = {a[31], a} + {b[31], b}; r.ao = wide[31:0]; r.ovf = wide[32] ^ wide[31]; end
            4'd1:  begin wide = {a[31], a} - {b[31], b}; r.ao = wide[31:0]; r.ovf = wide[32] ^ wide[31]; end
            4'd2:  r.ao = a & b;
            4'd3:  r.ao = a | b;
            4'd4:  r.ao = a ^ b;
            4'd5:  r.ao = ~a & ~b;
            4'd6:  r.ao = (a[31] != b[31]) ? {31'd0, a[31]} : {31'd0, a < b};
            4'd7:  r.ao = {31'd0, a < b};
            4'd8:  r.ao = b << 16;
            4'd9, 4'd12: r.ao = b * (33'd1 << n);
            4'd10, 4'd13: r.ao = b / (33'd1 << n);
            default: begin
                if (c == 4'd15) r.ao = b;
                else r.ao = (b >> n) | (b[31] ? ~(32'hFFFF_FFFF >> n) : 32'd0);
            end
        endcase
        return r;
    endfunction

    // Drive one op with en=1, check the combinational outputs, then the registered copy.
    task automatic apply(input vec_t v, input string name);
        sb_t e;
        sb_t got;
        @(negedge clk);
        bus.ALUCtrl = v.ctrl;
        bus.SrcA_E  = v.a;
        bus.SrcB_E  = v.b;
        bus.Shift_E = v.sh;
        bus.en      = 1'b1;
        bus.clr     = 1'b0;
        #1;
        check({name, " AO_E"}, bus.AO_E, v.exp_ao);
        check({name, " Ovf_E"}, {31'd0, bus.Ovf_E}, {31'd0, v.exp_ovf});
        e.ao  = v.exp_ao;
        e.ovf = v.exp_ovf;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        got = sb_q.pop_front();
        check({name, " AO_M"}, bus.AO_M, got.ao);
        check({name, " Ovf_M"}, {31'd0, bus.Ovf_M}, {31'd0, got.ovf});
    endtask

    task automatic drive(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                         input logic en, input logic clr);
        bus.ALUCtrl = c;
        bus.SrcA_E  = a;
        bus.SrcB_E  = b;
        bus.Shift_E = 5'd0;
        bus.en      = en;
        bus.clr     = clr;
    endtask

    initial begin
        vec_t v;
        sb_t  m;

        vecs.push_back('{ALU_SRL,   32'h0000_0000, 32'hFAB6_E829, 5'd13, 32'h0007_D5B7, 1'b0});
        vecs.push_back('{ALU_SRA,   32'h0000_0000, 32'hFAB6_E829, 5'd13, 32'hFFFF_D5B7, 1'b0});
        vecs.push_back('{ALU_SLL,   32'h0000_0000, 32'hFAB6_E829, 5'd13, 32'hDD05_2000, 1'b0});
        vecs.push_back('{ALU_SLLV,  32'h0000_000D, 32'hFAB6_E829, 5'd0,  32'hDD05_2000, 1'b0});
        vecs.push_back('{ALU_SLLV,  32'hFFFF_FFED, 32'hFAB6_E829, 5'd3,  32'hDD05_2000, 1'b0});
        vecs.push_back('{ALU_ADD,   32'h7FFF_FFFF, 32'h0000_0001, 5'd0,  32'h8000_0000, 1'b1});
        vecs.push_back('{ALU_SUB,   32'h8000_0000, 32'h0000_0001, 5'd0,  32'h7FFF_FFFF, 1'b1});
        vecs.push_back('{ALU_ADD,   32'hFFFF_FFFF, 32'h0000_0001, 5'd0,  32'h0000_0000, 1'b0});
        vecs.push_back('{ALU_SUB,   32'h0000_0001, 32'h0000_0002, 5'd0,  32'hFFFF_FFFF, 1'b0});
        vecs.push_back('{ALU_SUB,   32'h7FFF_FFFF, 32'hFFFF_FFFF, 5'd0,  32'h8000_0000, 1'b1});
        vecs.push_back('{ALU_SLT,   32'hFFFF_FFFF, 32'h0000_0001, 5'd0,  32'h0000_0001, 1'b0});
        vecs.push_back('{ALU_SLTU,  32'hFFFF_FFFF, 32'h0000_0001, 5'd0,  32'h0000_0000, 1'b0});
        vecs.push_back('{ALU_NOR,   32'hFFFF_FFFF, 32'h0000_0001, 5'd0,  32'h0000_0000, 1'b0});
        vecs.push_back('{ALU_XOR,   32'hFFFF_FFFF, 32'h0000_0001, 5'd0,  32'hFFFF_FFFE, 1'b0});
        vecs.push_back('{ALU_LUI,   32'h0000_0000, 32'h0000_1234, 5'd0,  32'h1234_0000, 1'b0});
        vecs.push_back('{ALU_AND,   32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0,  32'hF000_F000, 1'b0});
        vecs.push_back('{ALU_OR,    32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0,  32'hFFF0_FFF0, 1'b0});
        vecs.push_back('{ALU_PASSB, 32'h0000_0001, 32'hDEAD_BEEF, 5'd7,  32'hDEAD_BEEF, 1'b0});
        vecs.push_back('{ALU_SRAV,  32'h0000_0020, 32'h8000_0000, 5'd9,  32'h8000_0000, 1'b0});
        vecs.push_back('{ALU_SRLV,  32'h0000_003F, 32'h8000_0000, 5'd0,  32'h0000_0001, 1'b0});
        vecs.push_back('{ALU_SRA,   32'h0000_0000, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 1'b0});

        rst_n = 1'b1;
        drive(ALU_PASSB, 32'd0, 32'd0, 1'b0, 1'b0);
        #1 rst_n = 1'b0;
        #11;
        check("reset AO_M", bus.AO_M, 32'd0);
        check("reset Ovf_M", {31'd0, bus.Ovf_M}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) apply(vecs[i], $sformatf("vec%0d", i));

        // Stall and flush.
        @(negedge clk);
        drive(ALU_PASSB, 32'd0, 32'h0000_1234, 1'b1, 1'b0);
        @(posedge clk); #1;
        check("load AO_M", bus.AO_M, 32'h0000_1234);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            drive(4'($urandom_range(0, 15)), $urandom, $urandom, 1'b0, 1'b0);
            @(posedge clk); #1;
            check($sformatf("stall%0d AO_M", i), bus.AO_M, 32'h0000_1234);
        end
        @(negedge clk);
        drive(ALU_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 1'b1, 1'b0);
        @(posedge clk); #1;
        check("ovf load Ovf_M", {31'd0, bus.Ovf_M}, 32'd1);
        @(negedge clk);
        drive(ALU_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 1'b1, 1'b1);
        @(posedge clk); #1;
        check("clr AO_M", bus.AO_M, 32'd0);
        check("clr Ovf_M", {31'd0, bus.Ovf_M}, 32'd0);

        // Asynchronous reset mid-cycle, then first load after release.
        @(negedge clk);
        drive(ALU_PASSB, 32'd0, 32'h0000_55AA, 1'b1, 1'b0);
        @(posedge clk); #1;
        check("pre-reset AO_M", bus.AO_M, 32'h0000_55AA);
        #2 rst_n = 1'b0;
        #1;
        check("async rst AO_M", bus.AO_M, 32'd0);
        check("async rst Ovf_M", {31'd0, bus.Ovf_M}, 32'd0);
        @(posedge clk); #1;
        check("rst held AO_M", bus.AO_M, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(ALU_PASSB, 32'd0, 32'h0000_0BAD, 1'b1, 1'b0);
        @(posedge clk); #1;
        check("post-rst AO_M", bus.AO_M, 32'h0000_0BAD);

        // Random sweep over every opcode, forcing shift amounts 0 and 31.
        for (int c = 0; c < 16; c++) begin
            for (int k = 0; k < 8; k++) begin
                v.ctrl = 4'(c);
                v.a    = $urandom;
                v.b    = $urandom;
                v.sh   = 5'($urandom);
                if (k == 0) begin v.sh = 5'd0;  v.a[4:0] = 5'd0;  end
                if (k == 1) begin v.sh = 5'd31; v.a[4:0] = 5'd31; end
                if (k == 2) v.b = v.a;
                v.a[31:5] = v.a[31:5] | 27'h1;
                m         = model(v.ctrl, v.a, v.b, v.sh);
                v.exp_ao  = m.ao;
                v.exp_ovf = m.ovf;
                apply(v, $sformatf("rnd op%0d #%0d", c, k));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
